axo_fetch_queue: RTL and testbench

- Instruction fetch and prefetch buffer sitting directly upstream of decode (insn validator, register decoder, branch target unit).
- Issues word-aligned fetches to an in-order memory port and queues returned instructions with their PC.
- Presents queued instructions one at a time to decode.
- Redirects on flush (branch/jump/mret target, or trap vector) and discards stale in-flight responses.

---
 rtl/axo_fetch_queue.sv | 157 +++++++++++++++
 tb/tb_axo_fetch_queue.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axo_fetch_queue.sv
// axo_fetch_queue: instruction fetch/prefetch buffer in front of decode.
// Issues word fetches to an in-order memory port and queues the returned
// words with their PC, presenting them one at a time to decode.
// Ports:
//   clk, rst                 clock, async active-high reset
//   fetch_req/addr/ack       request side of the memory port
//   resp_valid/data/err      in-order response side (no backpressure)
//   flush, flush_pc          redirect; drops queue and in-flight fetches
//   out_valid/ready          decode handshake
//   out_insn/pc/fault/misal  head entry fields
module axo_fetch_queue #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [29:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        resp_err,
  input  logic        flush,
  input  logic [30:0] flush_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [30:0] out_pc,
  output logic        out_fault,
  output logic        out_misalign
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [29:0]   fpc_q, fpc_d;
  logic [30:0]   epc_q, epc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ost_q, ost_d;
  logic [CW-1:0] dis_q, dis_d;
  logic          stall_q, stall_d;
  logic          mis_q, mis_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;

  logic [31:0]      insn_m [DEPTH];
  logic [30:0]      pc_m   [DEPTH];
  logic [DEPTH-1:0] flt_m;
  logic [DEPTH-1:0] mis_m;

  logic [CW:0] used;
  logic        accept;
  logic        drop;
  logic        push_r;
  logic        push;
  logic        pop;
  logic        have;
  logic [31:0] w_insn;
  logic        w_flt;

  // Credit rule: queued + in flight never exceeds DEPTH, so every
  // response is guaranteed a free slot.
  assign used = {1'b0, cnt_q} + {1'b0, ost_q};

  assign fetch_req = !rst && !flush && !stall_q &&
                     (used < (CW+1)'(DEPTH));
  assign fetch_addr = rst ? '0 : fpc_q;

  assign accept = fetch_req && fetch_ack;
  assign drop   = resp_valid && (dis_q != '0);
  assign push_r = resp_valid && (dis_q == '0);
  // A pending misaligned-target entry and a live response cannot meet:
  // every fetch in flight at that flush is marked for discard.
  assign push   = !flush && (mis_q || push_r);

  assign have      = cnt_q != '0;
  assign out_valid = have && !flush;
  assign pop       = out_valid && out_ready;

  assign out_insn     = have ? insn_m[rp_q] : '0;
  assign out_pc       = have ? pc_m[rp_q]   : '0;
  assign out_fault    = have ? flt_m[rp_q]  : 1'b0;
  assign out_misalign = have ? mis_m[rp_q]  : 1'b0;

  assign w_insn = (mis_q || resp_err) ? '0 : resp_data;
  assign w_flt  = !mis_q && resp_err;

  always_comb begin
    fpc_d   = fpc_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    ost_d   = ost_q;
    dis_d   = dis_q;
    stall_d = stall_q;
    mis_d   = 1'b0;
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (flush) begin
      fpc_d   = flush_pc[30:1];
      epc_d   = flush_pc;
      cnt_d   = '0;
      wp_d    = '0;
      rp_d    = '0;
      // A response landing in the flush cycle is already stale.
      ost_d   = ost_q - CW'(resp_valid);
      dis_d   = ost_q - CW'(resp_valid);
      stall_d = flush_pc[0];
      mis_d   = flush_pc[0];
    end else begin
      if (accept) fpc_d = fpc_q + 30'd1;
      ost_d = ost_q + CW'(accept) - CW'(resp_valid);
      if (drop) dis_d = dis_q - CW'(1);
      if (push) begin
        wp_d  = wp_q + AW'(1);
        epc_d = epc_q + 31'd2;
      end
      if (pop) rp_d = rp_q + AW'(1);
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      stall_d = stall_q || (push_r && resp_err) || mis_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q   <= RESET_VECTOR[31:2];
      epc_q   <= RESET_VECTOR[31:1];
      cnt_q   <= '0;
      ost_q   <= '0;
      dis_q   <= '0;
      stall_q <= 1'b0;
      mis_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      fpc_q   <= fpc_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
      ost_q   <= ost_d;
      dis_q   <= dis_d;
      stall_q <= stall_d;
      mis_q   <= mis_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // Entry storage is only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      insn_m[wp_q] <= w_insn;
      pc_m[wp_q]   <= epc_q;
      flt_m[wp_q]  <= w_flt;
      mis_m[wp_q]  <= mis_q;
    end
  end

endmodule

// File: tb/tb_axo_fetch_queue.sv
// tb_axo_fetch_queue: randomized and directed bench for axo_fetch_queue
// against a transaction-level model built from queues.
module tb_axo_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req;
  logic [29:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        resp_err = 1'b0;
  logic        flush = 1'b0;
  logic [30:0] flush_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_insn;
  logic [30:0] out_pc;
  logic        out_fault;
  logic        out_misalign;

  axo_fetch_queue #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err),
    .flush(flush), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_pc(out_pc),
    .out_fault(out_fault), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic        err;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] insn;
    logic [30:0] pc;
    logic        flt;
    logic        mis;
  } ent_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t        mem_q[$];
  ent_t        exp_q[$];
  logic [31:0] acc_data[$];
  logic [29:0] m_fpc;
  int          m_epoch = 0;
  bit          m_stall;
  bit          m_mis_pend;
  logic [30:0] m_mis_pc;

  int          lat_min = 1;
  int          lat_max = 1;
  int          resp_pct = 100;
  int          err_pct = 0;
  bit          err_word_en = 0;
  logic [29:0] err_word = '0;

  bit          o_acc;
  bit          o_rv;
  bit          d_req;
  logic [29:0] d_addr;
  bit          d_val;
  logic [31:0] d_insn;
  logic [30:0] d_pc;
  bit          d_flt;
  bit          d_mis;

  task automatic model_clear();
    mem_q.delete();
    exp_q.delete();
    acc_data.delete();
    m_fpc = '0;
    m_stall = 0;
    m_mis_pend = 0;
    m_epoch++;
  endtask

  task automatic do_reset(input int dly);
    @(negedge clk);
    #(dly);
    rst = 1'b1;
    flush = 0; fetch_ack = 0; resp_valid = 0;
    resp_err = 0; out_ready = 0; flush_pc = '0;
    #1;
    checks++;
    if ({fetch_req, fetch_addr, out_valid, out_insn, out_pc,
         out_fault, out_misalign} !== '0)
      begin
        errors++;
        $display("FAIL reset_outputs t=%0t got req=%b addr=%h v=%b",
                 $time, fetch_req, fetch_addr, out_valid,
                 " insn=%h pc=%h f=%b m=%b exp all 0",
                 out_insn, out_pc, out_fault, out_misalign);
      end
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare DUT outputs with the model, then
  // advance the model to reflect the upcoming rising edge.
  task automatic step(input bit fl, input logic [30:0] fpc,
                      input bit ack, input bit rdy);
    bit   e_req;
    bit   e_val;
    bit   rv;
    req_t r;
    ent_t e;
    @(negedge clk);
    rv = mem_q.size() > 0 && mem_q[0].due <= cyc &&
         ($urandom_range(99) < resp_pct);
    resp_valid = rv;
    resp_data  = rv ? mem_q[0].data : $urandom;
    resp_err   = rv ? mem_q[0].err : 1'($urandom_range(1));
    flush      = fl;
    flush_pc   = fpc;
    fetch_ack  = ack;
    out_ready  = rdy;
    #1;
    d_req = fetch_req;  d_addr = fetch_addr;
    d_val = out_valid;  d_insn = out_insn;
    d_pc  = out_pc;     d_flt  = out_fault;
    d_mis = out_misalign;
    e_val = exp_q.size() > 0 && !fl;
    e_req = !fl && !m_stall && (exp_q.size() + mem_q.size() < DEPTH);
    checks++;
    if (out_valid !== e_val) begin
      errors++;
      $display("FAIL out_valid cyc=%0d got %b exp %b",
               cyc, out_valid, e_val);
    end
    if (e_val) begin
      checks++;
      if ({out_insn, out_pc, out_fault, out_misalign} !==
          {exp_q[0].insn, exp_q[0].pc, exp_q[0].flt, exp_q[0].mis}) begin
        errors++;
        $display("FAIL head cyc=%0d got %h/%h/%b/%b exp %h/%h/%b/%b",
                 cyc, out_insn, out_pc, out_fault, out_misalign,
                 exp_q[0].insn, exp_q[0].pc, exp_q[0].flt, exp_q[0].mis);
      end
    end
    checks++;
    if (fetch_req !== e_req) begin
      errors++;
      $display("FAIL fetch_req cyc=%0d got %b exp %b",
               cyc, fetch_req, e_req);
    end
    if (e_req) begin
      checks++;
      if (fetch_addr !== m_fpc) begin
        errors++;
        $display("FAIL fetch_addr cyc=%0d got %h exp %h",
                 cyc, fetch_addr, m_fpc);
      end
    end
    o_acc = e_req && ack;
    o_rv  = rv;
    if (e_val && rdy) void'(exp_q.pop_front());
    if (rv) begin
      r = mem_q.pop_front();
      if (!fl && r.epoch == m_epoch) begin
        e.insn = r.err ? 32'h0 : r.data;
        e.pc   = {r.addr, 1'b0};
        e.flt  = r.err;
        e.mis  = 1'b0;
        exp_q.push_back(e);
        if (r.err) m_stall = 1;
      end
    end
    if (m_mis_pend && !fl) begin
      e.insn = '0; e.pc = m_mis_pc; e.flt = 0; e.mis = 1;
      exp_q.push_back(e);
    end
    m_mis_pend = 0;
    if (o_acc) begin
      r.addr  = m_fpc;
      r.data  = $urandom;
      r.err   = (err_word_en && m_fpc == err_word) ||
                ($urandom_range(99) < err_pct);
      r.epoch = m_epoch;
      r.due   = cyc + $urandom_range(lat_max, lat_min);
      mem_q.push_back(r);
      acc_data.push_back(r.data);
      m_fpc = m_fpc + 30'd1;
    end
    if (fl) begin
      exp_q.delete();
      m_epoch++;
      m_fpc      = fpc[30:1];
      m_stall    = fpc[0];
      m_mis_pend = fpc[0];
      m_mis_pc   = fpc;
    end
    cyc++;
  endtask

  task automatic set_mem(input int lmin, input int lmax,
                         input int pct, input int epct);
    lat_min = lmin; lat_max = lmax;
    resp_pct = pct; err_pct = epct;
  endtask

  task automatic test_reset();
    do_reset(0);
    step(0, '0, 0, 0);
    checks++;
    if (d_req !== 1'b1 || d_addr !== 30'h0 || d_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got req=%b addr=%h v=%b exp 1/0/0",
               d_req, d_addr, d_val);
    end
  endtask

  task automatic test_stream();
    int nacc = 0;
    int npop = 0;
    int fa = -1;
    int fv = -1;
    do_reset(0);
    set_mem(1, 1, 100, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 1, 1);
      if (o_acc) begin
        if (fa < 0) fa = i;
        checks++;
        if (d_addr !== 30'(nacc)) begin
          errors++;
          $display("FAIL stream_addr got %h exp %h", d_addr, nacc);
        end
        nacc++;
      end
      if (d_val) begin
        if (fv < 0) fv = i;
        checks++;
        if (d_pc !== 31'(2 * npop) || d_insn !== acc_data[npop]) begin
          errors++;
          $display("FAIL stream_out got %h/%h exp %h/%h",
                   d_pc, d_insn, 2 * npop, acc_data[npop]);
        end
        npop++;
      end
    end
    checks++;
    if (fv - fa != 2 || npop < 12) begin
      errors++;
      $display("FAIL stream_latency got %0d pops %0d exp 2 and >=12",
               fv - fa, npop);
    end
  endtask

  task automatic test_fill();
    int n = 0;
    do_reset(0);
    set_mem(1, 1, 100, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, '0, 1, 0);
      if (o_acc) n++;
    end
    checks++;
    if (n != DEPTH || d_req !== 1'b0 || d_val !== 1'b1) begin
      errors++;
      $display("FAIL fill got acc=%0d req=%b v=%b exp 4/0/1",
               n, d_req, d_val);
    end
    step(0, '0, 1, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, 0);
      if (o_acc) n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL fill_one_slot got %0d exp 1", n);
    end
  endtask

  task automatic wait_entry(input logic [30:0] epc,
                            input logic [31:0] einsn,
                            input string nm);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(0, '0, 0, 0);
      seen = d_val;
    end
    checks++;
    if (!seen || d_pc !== epc || d_insn !== einsn) begin
      errors++;
      $display("FAIL %s seen=%b got %h/%h exp %h/%h",
               nm, seen, d_pc, d_insn, epc, einsn);
    end
  endtask

  task automatic test_flush_discard();
    do_reset(0);
    set_mem(6, 6, 100, 0);
    repeat (3) step(0, '0, 1, 0);
    step(1, 31'h40, 1, 0);
    step(0, '0, 1, 0);
    checks++;
    if (d_addr !== 30'h20 || !o_acc) begin
      errors++;
      $display("FAIL flush_addr got %h acc=%b exp 20/1", d_addr, o_acc);
    end
    wait_entry(31'h40, acc_data[3], "flush_first_entry");
  endtask

  task automatic test_flush_same_cycle();
    do_reset(0);
    set_mem(3, 3, 100, 0);
    repeat (2) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    step(1, 31'h20, 1, 0);
    checks++;
    if (!o_rv) begin
      errors++;
      $display("FAIL same_cycle_resp got %b exp 1", o_rv);
    end
    step(0, '0, 1, 0);
    wait_entry(31'h20, acc_data[2], "same_cycle_entry");
  endtask

  task automatic test_fault();
    bit seen = 0;
    do_reset(0);
    set_mem(1, 1, 100, 0);
    err_word_en = 1;
    err_word = 30'h40;
    step(1, 31'h80, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 1, 0);
      if (d_val && !seen) begin
        seen = 1;
        checks++;
        if (d_flt !== 1'b1 || d_insn !== 32'h0 || d_pc !== 31'h80) begin
          errors++;
          $display("FAIL fault_entry got %b/%h/%h exp 1/0/80",
                   d_flt, d_insn, d_pc);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, 1);
      checks++;
      if (d_req !== 1'b0) begin
        errors++;
        $display("FAIL fault_stall got %b exp 0", d_req);
      end
    end
    err_word_en = 0;
    step(1, 31'h0, 0, 1);
    step(0, '0, 1, 1);
    checks++;
    if (d_req !== 1'b1 || d_addr !== 30'h0) begin
      errors++;
      $display("FAIL fault_resume got %b/%h exp 1/0", d_req, d_addr);
    end
  endtask

  task automatic test_misalign();
    do_reset(0);
    set_mem(1, 2, 100, 0);
    step(1, 31'h41, 1, 0);
    step(0, '0, 1, 0);
    checks++;
    if (d_req !== 1'b0 || d_val !== 1'b0) begin
      errors++;
      $display("FAIL mis_gap got %b/%b exp 0/0", d_req, d_val);
    end
    step(0, '0, 1, 1);
    checks++;
    if (d_val !== 1'b1 || d_mis !== 1'b1 || d_pc !== 31'h41 ||
        d_insn !== 32'h0 || d_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_entry got v=%b m=%b pc=%h i=%h r=%b exp 1/1/41/0/0",
               d_val, d_mis, d_pc, d_insn, d_req);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, 1);
      checks++;
      if (d_req !== 1'b0 || d_val !== 1'b0) begin
        errors++;
        $display("FAIL mis_idle got %b/%b exp 0/0", d_req, d_val);
      end
    end
    step(1, 31'h10, 0, 1);
    repeat (6) step(0, '0, 1, 1);
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    set_mem(3, 7, 80, 0);
    repeat (4) step(0, '0, 1, 0);
    step(1, 31'h100, 1, 0);
    step(1, 31'h7FFF_FFFC, 1, 0);
    step(1, 31'h7FFF_FFF8, 1, 0);
    repeat (40) step(0, '0, 1, $urandom_range(1));
  endtask

  task automatic run_random(input int n);
    logic [30:0] p;
    bit          fl;
    set_mem(1, 5, 70, 3);
    for (int i = 0; i < n; i++) begin
      fl = $urandom_range(39) == 0;
      p  = 31'($urandom);
      if ($urandom_range(7) != 0) p[0] = 1'b0;
      step(fl, p, $urandom_range(9) < 7, $urandom_range(9) < 6);
    end
  endtask

  task automatic test_random();
    do_reset(0);
    run_random(1500);
    do_reset(3);
    run_random(1500);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_flush_discard();
    test_flush_same_cycle();
    test_fault();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
